spr_param_ram: RTL and testbench



---
 rtl/spr_ram_pkg.sv | 23 ++
 rtl/spr_clear_seq.sv | 63 ++++++
 rtl/spr_param_ram.sv | 95 +++++++++
 tb/tb_spr_param_ram.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/spr_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spr_ram_pkg
// Description : Shared types and helpers for the parametrised single-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
package spr_ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int RDW_READ_FIRST    = 0;
    localparam int RDW_WRITE_THROUGH = 1;

    // One spare bit so a full 2**ADDR_WIDTH clear can count past its last word.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spr_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : spr_clear_seq
// Description : Post-reset clear sequencer; walks every word writing INIT_VALUE.
// Revision    : 1.0 - initial release
// ============================================================================
module spr_clear_seq
    import spr_ram_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter int                    DATA_WIDTH = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output logic [DATA_WIDTH-1:0] o_clr_data
);

    localparam int            CW     = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] c_last = CW'(DEPTH - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            ST_INIT: begin
                w_count_next = r_count + 1'b1;
                if (r_count == c_last) begin
                    w_state_next = ST_READY;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
    end

    assign o_busy     = (r_state == ST_INIT);
    assign o_clr_we   = o_busy & ~rst;
    assign o_clr_addr = r_count[ADDR_WIDTH-1:0];
    assign o_clr_data = INIT_VALUE;

endmodule
`default_nettype wire

// File: rtl/spr_param_ram.sv
`default_nettype none
// ============================================================================
// Module      : spr_param_ram
// Description : Parametrised single-port distributed RAM with self-clearing start-up.
// Revision    : 1.0 - initial release
// ============================================================================
module spr_param_ram
    import spr_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    ADDR_WIDTH = 4,
    parameter int                    DEPTH      = 2**ADDR_WIDTH,
    parameter int                    OUT_REG    = 0,
    parameter int                    RDW_MODE   = RDW_READ_FIRST,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] AD,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  WRE,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  BUSY
);

    localparam int            CW      = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic [DATA_WIDTH-1:0] w_clr_data;
    logic                  w_in_range;
    logic                  w_user_we;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_data;

    spr_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_clear_seq (
        .clk        (CK),
        .rst        (RST),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_clr_data (w_clr_data)
    );

    assign w_in_range = ({1'b0, AD} < c_depth);

    // Only a clean 1 on WRE counts; reset and the clear sequence both lock out the user.
    assign w_user_we = ~w_busy & ~RST & (WRE === 1'b1) & w_in_range;

    assign w_we    = w_clr_we | w_user_we;
    assign w_waddr = w_busy ? w_clr_addr : AD;
    assign w_wdata = w_busy ? w_clr_data : DI;

    always_ff @(posedge CK) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    assign w_rd_data = w_in_range ? r_mem[AD] : '0;
    assign BUSY      = w_busy;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_do;

            always_ff @(posedge CK) begin
                if (RST || w_busy) begin
                    r_do <= '0;
                end else if (w_user_we && (RDW_MODE == RDW_WRITE_THROUGH)) begin
                    r_do <= DI;
                end else begin
                    r_do <= w_rd_data;
                end
            end

            assign DO = r_do;
        end else begin : g_async_rd
            assign DO = w_busy ? '0 : w_rd_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spr_param_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_spr_param_ram
// Description : Directed self-checking bench over four RAM configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spr_param_ram;

    logic       CK;
    logic       RST;
    logic [3:0] AD;
    logic [1:0] DI;
    logic       WRE;

    logic [1:0] do_a, do_b, do_c, do_d;
    logic       busy_a, busy_b, busy_c, busy_d;

    int vectors = 0;
    int errors  = 0;

    // A: async read, INIT 2'b10; B/C: registered read-first / write-through; D: 12 words
    spr_param_ram #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(0),
                    .RDW_MODE(0), .INIT_VALUE(2'b10)) u_a (
        .CK(CK), .RST(RST), .AD(AD), .DI(DI), .WRE(WRE), .DO(do_a), .BUSY(busy_a));
    spr_param_ram #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(1),
                    .RDW_MODE(0), .INIT_VALUE(2'b00)) u_b (
        .CK(CK), .RST(RST), .AD(AD), .DI(DI), .WRE(WRE), .DO(do_b), .BUSY(busy_b));
    spr_param_ram #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(1),
                    .RDW_MODE(1), .INIT_VALUE(2'b00)) u_c (
        .CK(CK), .RST(RST), .AD(AD), .DI(DI), .WRE(WRE), .DO(do_c), .BUSY(busy_c));
    spr_param_ram #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .DEPTH(12), .OUT_REG(0),
                    .RDW_MODE(0), .INIT_VALUE(2'b01)) u_d (
        .CK(CK), .RST(RST), .AD(AD), .DI(DI), .WRE(WRE), .DO(do_d), .BUSY(busy_d));

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b1;
        WRE = 1'b1;
        DI  = 2'b11;
        AD  = 4'd0;
        tick();
        tick();
        check("rst_busy_a", {1'b0, busy_a}, 2'b01);
        check("rst_busy_d", {1'b0, busy_d}, 2'b01);
        check("rst_do_a", do_a, 2'b00);
        check("rst_do_b", do_b, 2'b00);
        check("rst_do_c", do_c, 2'b00);

        // Clear runs while WRE=1/DI=11 is held; D finishes after 12 edges and then sees out-of-range writes
        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            AD = 4'(i);
            #1;
            check("clr_busy_a", {1'b0, busy_a}, 2'b01);
            check("clr_busy_d", {1'b0, busy_d}, (i < 12) ? 2'b01 : 2'b00);
            check("clr_do_a", do_a, 2'b00);
            check("clr_do_d", do_d, 2'b00);
            check("clr_do_b", do_b, 2'b00);
            tick();
        end
        WRE = 1'b0;
        #1;
        check("ready_busy_a", {1'b0, busy_a}, 2'b00);
        check("ready_busy_c", {1'b0, busy_c}, 2'b00);

        for (int k = 0; k < 16; k++) begin
            AD = 4'(k);
            #1;
            check("init_a", do_a, 2'b10);
            check("init_d", do_d, (k < 12) ? 2'b01 : 2'b00);
        end

        AD = 4'd7;
        tick();
        check("init_b", do_b, 2'b00);
        check("init_c", do_c, 2'b00);

        // Write 01 to address 5
        AD  = 4'd5;
        DI  = 2'b01;
        WRE = 1'b1;
        tick();
        WRE = 1'b0;
        check("wr5_rdw0", do_b, 2'b00);
        check("wr5_rdw1", do_c, 2'b01);
        for (int k = 0; k < 16; k++) begin
            AD = 4'(k);
            #1;
            check("sweep_a", do_a, (k == 5) ? 2'b01 : 2'b10);
            check("sweep_d", do_d, (k < 12) ? 2'b01 : 2'b00);
            check("sweep_b_hold", do_b, 2'b00);
        end
        AD = 4'd5;
        tick();
        check("rd5_b", do_b, 2'b01);
        check("rd5_c", do_c, 2'b01);

        // Read-during-write on address 3
        AD = 4'd3;
        tick();
        check("pre3_b", do_b, 2'b00);
        check("pre3_c", do_c, 2'b00);
        DI  = 2'b11;
        WRE = 1'b1;
        tick();
        WRE = 1'b0;
        check("rdw3_b", do_b, 2'b00);
        check("rdw3_c", do_c, 2'b11);
        check("rdw3_a", do_a, 2'b11);
        tick();
        check("post3_b", do_b, 2'b11);
        check("post3_c", do_c, 2'b11);

        // Out-of-range write to D leaves it untouched
        AD  = 4'd13;
        DI  = 2'b10;
        WRE = 1'b1;
        tick();
        WRE = 1'b0;
        check("oor_d", do_d, 2'b00);
        check("oor_a", do_a, 2'b10);

        // Reset, clear 7 words, reset again mid-clear
        RST = 1'b1;
        tick();
        check("rrst_do_b", do_b, 2'b00);
        check("rrst_busy_a", {1'b0, busy_a}, 2'b01);
        RST = 1'b0;
        WRE = 1'b1;
        DI  = 2'b11;
        for (int i = 0; i < 7; i++) begin
            AD = 4'(i);
            tick();
            check("part_busy_a", {1'b0, busy_a}, 2'b01);
            check("part_do_a", do_a, 2'b00);
        end
        RST = 1'b1;
        tick();
        check("mid_do_c", do_c, 2'b00);
        RST = 1'b0;
        for (int i = 0; i < 16; i++) begin
            AD = 4'(12 + (i % 4));
            #1;
            check("rclr_busy_a", {1'b0, busy_a}, 2'b01);
            check("rclr_busy_d", {1'b0, busy_d}, (i < 12) ? 2'b01 : 2'b00);
            check("rclr_do_a", do_a, 2'b00);
            check("rclr_do_c", do_c, 2'b00);
            tick();
        end
        WRE = 1'b0;
        #1;
        check("rready_busy_a", {1'b0, busy_a}, 2'b00);
        for (int k = 0; k < 16; k++) begin
            AD = 4'(k);
            #1;
            check("reinit_a", do_a, 2'b10);
            check("reinit_d", do_d, (k < 12) ? 2'b01 : 2'b00);
        end
        AD = 4'd3;
        tick();
        check("reinit_b3", do_b, 2'b00);
        check("reinit_c3", do_c, 2'b00);
        AD = 4'd5;
        tick();
        check("reinit_b5", do_b, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
